mem_access_unit: RTL and testbench

//  MEM-stage load/store engine between the EX/MEM latch and the MEM/WB latch. Takes effective address,

---
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one req/ack bus access per load/store, returns aligned/extended load data.
// Latency: an access occupies MEM for at least 3 cycles (IDLE, BUSY, DONE); non-accesses pass with no stall.
// Backpressure: stall_MEM freezes upstream until DONE; DONE holds Datai until adv. Option: MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUO_MEM,
    input  logic [31:0] rs2_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic        adv,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] Datai,
    output logic        stall_MEM,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_MEM,
`endif
    output logic        bus_err_MEM
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;
    logic        acc;
    logic [1:0]  a;
    logic        is_byte;
    logic        is_half;
    logic [3:0]  nxt_strb;
    logic [31:0] nxt_wdata;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;

    assign acc       = MemRead_MEM | MemWrite_MEM;
    assign a         = ALUO_MEM[1:0];
    // Result is ready only once the FSM sits in DONE; non-accesses never stall
    assign stall_MEM = acc && (state != DONE);

    // Size decode and byte-lane steering for the instruction currently in MEM
    always_comb begin
        is_byte   = (funct3_MEM == 3'b000) || (funct3_MEM == 3'b100);
        is_half   = (funct3_MEM == 3'b001) || (funct3_MEM == 3'b101);
        nxt_strb  = 4'b1111;
        nxt_wdata = rs2_MEM;
        if (is_byte) begin
            nxt_strb  = 4'b0001 << a;
            nxt_wdata = {4{rs2_MEM[7:0]}};
        end else if (is_half) begin
            nxt_strb  = 4'b0011 << {a[1], 1'b0};
            nxt_wdata = {2{rs2_MEM[15:0]}};
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    // Halves must be 2-byte aligned, words 4-byte aligned; bytes are always fine
    assign misaligned = (is_half && a[0]) || (!is_byte && !is_half && (a != 2'b00));
`endif

    // Pick the addressed byte/half out of the returned word using the latched lane, then extend
    always_comb begin
        case (ld_off)
            2'd1:    ld_b = mem_rdata[15:8];
            2'd2:    ld_b = mem_rdata[23:16];
            2'd3:    ld_b = mem_rdata[31:24];
            default: ld_b = mem_rdata[7:0];
        endcase
        ld_h = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_f3)
            3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b100:  ld_ext = {24'h0, ld_b};
            3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b101:  ld_ext = {16'h0, ld_h};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Access FSM: issue request, wait for ack or timeout, hold result until downstream advances
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_wstrb   <= 4'h0;
            Datai       <= 32'h0;
            bus_err_MEM <= 1'b0;
            cnt         <= 16'h0;
            ld_f3       <= 3'b000;
            ld_off      <= 2'b00;
`ifdef MISALIGN_TRAP_EN
            misalign_MEM <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
`ifdef MISALIGN_TRAP_EN
                        if (misaligned) begin
                            // Trap without touching the bus
                            state        <= DONE;
                            Datai        <= 32'h0;
                            misalign_MEM <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            state     <= BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite_MEM;
                            mem_addr  <= {ALUO_MEM[31:2], 2'b00};
                            mem_wdata <= nxt_wdata;
                            mem_wstrb <= nxt_strb;
                            cnt       <= 16'h0;
                            ld_f3     <= funct3_MEM;
                            ld_off    <= a;
                        end
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle still completes the access normally
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        Datai   <= mem_we ? 32'h0 : ld_ext;
                        state   <= DONE;
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        mem_req     <= 1'b0;
                        Datai       <= 32'h0;
                        bus_err_MEM <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 16'h1;
                    end
                end
                DONE: begin
                    if (adv) begin
                        state       <= IDLE;
                        bus_err_MEM <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                        misalign_MEM <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of directed accesses, hand sequences for reset/abort corners, random accesses.
// Expected values come from a byte-arithmetic model of the load/store rules; bus responder acks after a chosen delay.
// Every wait is bounded; a hung access is reported as a failed comparison.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [31:0] ALUO_MEM;
    logic [31:0] rs2_MEM;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic [2:0]  funct3_MEM;
    logic        adv;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] Datai;
    logic        stall_MEM;
    logic        bus_err_MEM;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_MEM;
`endif

    int n_chk;
    int n_fail;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ALUO_MEM(ALUO_MEM), .rs2_MEM(rs2_MEM),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .funct3_MEM(funct3_MEM), .adv(adv),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .Datai(Datai), .stall_MEM(stall_MEM),
`ifdef MISALIGN_TRAP_EN
        .misalign_MEM(misalign_MEM),
`endif
        .bus_err_MEM(bus_err_MEM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model (plain byte arithmetic) ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int m_lane(input logic [2:0] f3, input logic [31:0] addr);
        int s   = m_size(f3);
        int off = int'(addr % 4);
        if (s == 1) return off;
        if (s == 2) return (off / 2) * 2;
        return 0;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        int s = m_size(f3);
        return (s == 2 && (addr % 2) != 0) || (s == 4 && (addr % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] addr);
        longint m = (longint'(1) << m_size(f3)) - 1;
        return 4'(m << m_lane(f3, addr));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int s = m_size(f3);
        if (s == 1) return 32'(longint'(rs2 % 256) * 64'h01010101);
        if (s == 2) return 32'(longint'(rs2 % 65536) * 64'h00010001);
        return rs2;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int     s    = m_size(f3);
        longint span = longint'(1) << (8 * s);
        longint v    = (longint'(rdata) >> (8 * m_lane(f3, addr))) % span;
        if (f3[2] == 1'b0 && s < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // One complete access: present it, answer the bus, hold DONE for 'hold' cycles, then advance.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                              input int ack_dly, input int hold,
                              input logic [31:0] e_datai, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                              input logic e_err, input logic e_mis, input string tag);
        int stalls = 0, reqs = 0, dones = 0, busy_n = 0;
        int e_busy;
        bit fin = 0, req_seen = 0;
        e_busy = e_mis ? 0 : ((ack_dly < TO) ? ack_dly + 1 : TO);
        @(posedge clk); #1;
        MemRead_MEM = rd; MemWrite_MEM = wr; funct3_MEM = f3;
        ALUO_MEM = addr; rs2_MEM = wd; mem_rdata = rdat; adv = 1'b0; mem_ack = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (stall_MEM) stalls++;
            if (mem_req) begin
                reqs++;
                if (!req_seen) begin
                    req_seen = 1;
                    check({tag, ".addr"}, mem_addr, addr & 32'hFFFF_FFFC);
                    check({tag, ".we"}, 32'(mem_we), 32'(wr));
                    if (wr) begin
                        check({tag, ".wstrb"}, 32'(mem_wstrb), 32'(e_strb));
                        check({tag, ".wdata"}, mem_wdata, e_wdata);
                    end
                end
            end else if (!stall_MEM) begin
                dones++;
                check({tag, ".datai"}, Datai, e_datai);
                check({tag, ".bus_err"}, 32'(bus_err_MEM), 32'(e_err));
`ifdef MISALIGN_TRAP_EN
                check({tag, ".misalign"}, 32'(misalign_MEM), 32'(e_mis));
`endif
            end
            @(posedge clk); #1;
            if (adv) begin
                fin = 1;
            end else if (mem_req) begin
                mem_ack = (busy_n == ack_dly);
                busy_n++;
            end else if (!stall_MEM) begin
                // Stray acks and changing rdata while in DONE must not disturb the result
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                adv       = (dones >= hold);
            end else begin
                mem_ack = 1'b0;
            end
        end
        MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; adv = 1'b0; mem_ack = 1'b0;
        check({tag, ".complete"}, 32'(fin), 32'd1);
        check({tag, ".stall_cycles"}, 32'(stalls), 32'(1 + e_busy));
        check({tag, ".req_cycles"}, 32'(reqs), 32'(e_busy));
        check({tag, ".done_cycles"}, 32'(dones), 32'(hold + 1));
        @(negedge clk);
        check({tag, ".idle_stall"}, 32'(stall_MEM), 32'd0);
        check({tag, ".idle_err"}, 32'(bus_err_MEM), 32'd0);
`ifdef MISALIGN_TRAP_EN
        check({tag, ".idle_mis"}, 32'(misalign_MEM), 32'd0);
`endif
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          ack_dly;
        int          hold;
        logic [31:0] e_datai;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic        e_err;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,  0, 32'hDEADBEEF, 4'h0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0,  0, 32'hFFFFFF80, 4'h0, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 1,  0, 32'h00000080, 4'h0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80FF0000, 0,  0, 32'hFFFF80FF, 4'h0, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h80FF0000, 2,  1, 32'h000080FF, 4'h0, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h12345678, 32'h0,        0,  0, 32'h0,        4'b0010, 32'h78787878, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h12345678, 32'h0,        1,  0, 32'h0,        4'b1100, 32'h56785678, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0,        0,  0, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'h55AA55AA, 99, 2, 32'h0,        4'h0, 32'h0,        1'b1};
        tbl[9]  = '{1'b1, 1'b0, 3'b011, 32'h104, 32'h0,        32'h11223344, 3,  3, 32'h11223344, 4'h0, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h80FF7F01, 1,  0, 32'h00007F01, 4'h0, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 1'b1, 3'b010, 32'h300, 32'h0BADF00D, 32'h0,        7,  0, 32'h0,        4'b1111, 32'h0BADF00D, 1'b1};

        rst = 1'b1; ALUO_MEM = 32'h0; rs2_MEM = 32'h0; MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
        funct3_MEM = 3'b000; adv = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        mem_ack = 1'b1;
        @(negedge clk);
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.mem_wdata", mem_wdata, 32'h0);
        check("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst.Datai", Datai, 32'h0);
        check("rst.bus_err", 32'(bus_err_MEM), 32'd0);
        check("rst.stall", 32'(stall_MEM), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ack_ignored.req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].rs2, tbl[i].rdata,
                       tbl[i].ack_dly, tbl[i].hold, tbl[i].e_datai, tbl[i].e_strb, tbl[i].e_wdata,
                       tbl[i].e_err, 1'b0, $sformatf("tbl%0d", i));
        end

        // Reset during BUSY drops the transaction and returns to IDLE
        @(posedge clk); #1;
        MemRead_MEM = 1'b1; funct3_MEM = 3'b010; ALUO_MEM = 32'h400; mem_ack = 1'b0;
        @(posedge clk); #1;
        check("rstbusy.req_before", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstbusy.req_after", 32'(mem_req), 32'd0);
        check("rstbusy.stall_idle", 32'(stall_MEM), 32'd1);
        @(posedge clk); #1;
        check("rstbusy.reissue", 32'(mem_req), 32'd1);
        MemRead_MEM = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstbusy.cleared", 32'(mem_req), 32'd0);

`ifdef MISALIGN_TRAP_EN
        run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'hDEADBEEF, 0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, "mis_lw");
        run_access(1'b0, 1'b1, 3'b001, 32'h103, 32'h1234, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, "mis_sh");
`endif

        // Randomized accesses against the model
        for (int i = 0; i < 60; i++) begin
            int          sel, ackd, hold;
            logic [2:0]  f3;
            logic [31:0] addr, rs2v, rdat;
            logic        rd, wr, mis, err;
            sel  = int'($urandom_range(0, 2));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom; rs2v = $urandom; rdat = $urandom;
            ackd = int'($urandom_range(0, 5));
            hold = int'($urandom_range(0, 2));
            if (sel == 0) begin
                @(posedge clk); #1;
                MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; funct3_MEM = f3; ALUO_MEM = addr;
                @(negedge clk);
                check("rnd.pass_stall", 32'(stall_MEM), 32'd0);
                check("rnd.pass_req", 32'(mem_req), 32'd0);
            end else begin
                rd  = (sel == 1);
                wr  = (sel == 2);
                mis = m_mis(f3, addr);
                err = !mis && (ackd >= TO);
                run_access(rd, wr, f3, addr, rs2v, rdat, ackd, hold,
                           (wr || mis || err) ? 32'h0 : m_load(f3, addr, rdat),
                           m_strb(f3, addr), m_wdata(f3, rs2v), err, mis, $sformatf("rnd%0d", i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
